// File: rtl/kda_result_framer_if.sv
// kda_result_framer_if
//   Groups the upstream kda word handshake and the downstream ring packet
//   handshake of kda_result_framer.
//   en_i        accept enable (low blocks new words, drain continues)
//   v_i/data_i  upstream kda result word valid / 64-bit word
//   yumi_o      word consumed this cycle
//   v_o/data_o  ring packet valid / packet
//   ready_i     ring side can accept the packet
//   keys_done_o completed key count, mod 256
//   slave: the framer side; master: the driver of the framer.
interface kda_result_framer_if #(
  parameter int unsigned ring_width_p = 79
);
  logic                    en_i;
  logic                    v_i;
  logic [63:0]             data_i;
  logic                    yumi_o;
  logic                    v_o;
  logic [ring_width_p-1:0] data_o;
  logic                    ready_i;
  logic [7:0]              keys_done_o;

  modport slave (
    input  en_i, v_i, data_i, ready_i,
    output yumi_o, v_o, data_o, keys_done_o
  );

  modport master (
    output en_i, v_i, data_i, ready_i,
    input  yumi_o, v_o, data_o, keys_done_o
  );
endinterface

// File: rtl/kda_result_framer.sv
// kda_result_framer
//   Frames 64-bit kda result words into ring packets through a 2-entry
//   registered FIFO. Each packet carries the word, its index inside the key,
//   a last-word flag and the key sequence number:
//     [63:0] word, [65:64] index, [66] last, [74:67] key seq, rest zero.
//   Ports:
//     clk_i    sole clock, rising edge
//     reset_i  asynchronous active-high reset
//     bus      kda_result_framer_if.slave (word in, packet out, key count)
//   ring_width_p must be >= 75; words_per_key_p must be 1..4.
module kda_result_framer #(
  parameter int unsigned ring_width_p    = 79,
  parameter int unsigned words_per_key_p = 4
) (
  input logic              clk_i,
  input logic              reset_i,
  kda_result_framer_if.slave bus
);

  localparam logic [1:0] LastIdx = 2'(words_per_key_p - 1);

  // The FIFO is a head/tail register pair. data_o is driven straight from the
  // head register, so it stays put when the FIFO empties and has no
  // combinational path from data_i.
  logic [1:0]              count_q, count_d;
  logic [ring_width_p-1:0] head_q, head_d;
  logic [ring_width_p-1:0] tail_q, tail_d;
  logic [1:0]              idx_q, idx_d;
  logic [7:0]              seq_q, seq_d;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    enq;
  logic                    deq;
  logic                    last;
  logic [ring_width_p-1:0] pkt;

  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);

  // Gated by reset so nothing is consumed while reset is held or before the
  // first edge after release.
  assign enq  = bus.v_i & bus.en_i & ~fifo_full & ~reset_i;
  assign deq  = ~fifo_empty & bus.ready_i;
  assign last = (idx_q == LastIdx);

  always_comb begin
    pkt        = '0;
    pkt[63:0]  = bus.data_i;
    pkt[65:64] = idx_q;
    pkt[66]    = last;
    pkt[74:67] = seq_q;
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    idx_d   = idx_q;
    seq_d   = seq_q;

    if (enq) begin
      if (last) begin
        idx_d = 2'd0;
        seq_d = seq_q + 8'd1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end

    unique case ({enq, deq})
      2'b10: begin
        if (fifo_empty) begin
          head_d = pkt;
        end else begin
          tail_d = pkt;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // With one entry the head is left alone so data_o holds its value.
        if (fifo_full) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // enq implies not full, so exactly one entry: it leaves, new one is head.
        head_d = pkt;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      idx_q   <= 2'd0;
      seq_q   <= 8'd0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.yumi_o      = enq;
  assign bus.v_o         = ~fifo_empty;
  assign bus.data_o      = head_q;
  assign bus.keys_done_o = seq_q;

endmodule
